fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the dual-clock FIFO among `NUM_REQ` requesters in the write clock domain. Each requester presents a valid/ready stream with a burst delimiter. The arbiter grants one requester at a time for a bounded burst and drives the FIFO `wr_en`/`wr_data` directly. It honours the FIFO `full` flag combinationally, so no beat is ever written into a full FIFO or dropped.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `DATA_WIDTH`, 4: beat width; must equal the FIFO `DATA_WIDTH`.
- `MAX_BURST`, 4: maximum beats per grant; legal range 1..16.

- `wr_clk` in 1: write-domain clock; the only clock of this block.
- `wrst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: bit i set means requester i presents a beat.
- `req_data` in NUM_REQ*DATA_WIDTH: requester i's data is in slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last` in NUM_REQ: bit i marks the current beat of requester i as the final beat of its burst.
- `req_ready` out NUM_REQ: one-hot or zero; the beat of requester i is consumed when `req_valid[i] & req_ready[i]`.
- `fifo_full` in 1: the FIFO `full` flag.
- `fifo_wr_en` out 1: FIFO write enable.
- `fifo_wr_data` out DATA_WIDTH: FIFO write data.
- `grant_id` out clog2(NUM_REQ): current owner; meaningful only while `busy` is high.
- `busy` out 1: high in the BURST state.

## Operation
- Two states: IDLE and BURST.
  - Registers: `owner`, `rr_ptr`, `beat_cnt` of width clog2(MAX_BURST+1).
- **IDLE**
  - No transfer occurs: `req_ready` = 0 and `fifo_wr_en` = 0.
  - If any `req_valid` bit is set, the block selects the first set bit found by scanning from `rr_ptr` upward, wrapping from NUM_REQ-1 to 0.
  - On that selection it latches `owner`, clears `beat_cnt`, and moves to BURST on the next cycle.
- **BURST**
  - A transfer occurs when `req_valid[owner]` = 1 and `fifo_full` = 0.
  - On a transfer: `fifo_wr_en` = 1, `req_ready[owner]` = 1, `fifo_wr_data` = the owner's slice, and `beat_cnt` increments.
- **Burst end.** The block returns to IDLE on either of these events:
  - A transfer where `req_last[owner]` = 1 or `beat_cnt` = MAX_BURST-1.
  - A cycle where `req_valid[owner]` = 0 and `fifo_full` = 0 (the owner has abandoned the burst).
- **On burst end.** `rr_ptr` is set to `owner`+1, wrapping to 0 at NUM_REQ.
- **Full stall.**
  - While `fifo_full` = 1 in BURST: `fifo_wr_en` = 0, `req_ready` = 0, and `beat_cnt`, `owner` and the state all hold.
  - A deasserted `req_valid[owner]` during a full cycle does not end the burst.
- **Simultaneous events.** When `req_last` and `beat_cnt` = MAX_BURST-1 occur on the same transfer, the result is a single burst end.
  - Requests from non-owners are ignored until the next IDLE.
- **`fifo_wr_data` outside a transfer.** Equals the owner's slice in BURST and 0 in IDLE.
- **Reset.** Assertion at any time, including mid-burst, forces the following with no clock edge required:
  - state = IDLE, `owner` = 0, `rr_ptr` = 0, `beat_cnt` = 0;
  - all outputs = 0.

## Timing
- Arbitration latency: the first beat is written no earlier than 1 cycle after `req_valid` is seen in IDLE.
- Every burst is followed by exactly one IDLE cycle. Peak throughput is therefore MAX_BURST/(MAX_BURST+1).
- `fifo_wr_en` and `req_ready` are combinational from `fifo_full`, `req_valid` and the registered state. They must settle within the `wr_clk` cycle.
- `busy` and `grant_id` are pure register outputs.
- `fifo_full` is registered in the write controller and already accounts for the write being issued in the current cycle. No extra lookahead is applied here.

## Structure
- Shared package `fifo_arb_pkg` holds:
  - the state encodings `ST_IDLE` = 0 and `ST_BURST` = 1;
  - a clog2 function used for the `grant_id` and `beat_cnt` widths.
- One natural sub-module, `rr_pick`: a combinational round-robin picker.
  - Inputs: `req_valid` and `rr_ptr`.
  - Outputs: winning index and an any-valid flag.
- The top level contains the state register, counter, output mux and ready decode.
- Instantiated between the requesters and `fifo_top` `wr_en`/`wr_data`, with `fifo_full` taken from `fifo_top.full`.

## Test plan
- Requester 0 alone sends D0..D2 with `req_last` on D2, at MAX_BURST=4:
  - one IDLE cycle;
  - `fifo_wr_en` high for 3 consecutive cycles carrying D0, D1, D2;
  - then IDLE with `rr_ptr` = 1.
- All 4 requesters continuously valid, `req_last` never set, MAX_BURST=4:
  - grants in order 0, 1, 2, 3, 0;
  - each grant writes 4 beats followed by exactly 1 idle cycle.
- `fifo_full` held high for 2 cycles after beat 1 of a 4-beat burst:
  - `fifo_wr_en` and `req_ready` are low during those cycles;
  - `beat_cnt` holds at 1;
  - the burst resumes and writes exactly 4 beats in total.
- Owner 1 drops `req_valid` after 2 beats while the FIFO is not full:
  - return to IDLE, `rr_ptr` = 2;
  - requester 2, which is pending, is granted next.
- `wrst_n` asserted mid-burst while owner is 2:
  - all outputs read 0 in the same cycle;
  - after release, with requesters 0 and 2 both valid, requester 0 is granted.
- MAX_BURST=1 with requesters 0 and 1 valid:
  - alternating single-beat grants 0, 1, 0, 1, each separated by one IDLE cycle.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encodings and width helper for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Minimum width able to index/count 'value' distinct values, never below 1 bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting at rr_ptr
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   pick,
  output logic               any_valid
);

  localparam logic [PTR_W:0] NUM_W = (PTR_W + 1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [PTR_W-1:0]     offset;
  logic [PTR_W:0]       sum;

  // Rotate so that bit 0 of rot is the requester at rr_ptr.
  assign dbl       = {req_valid, req_valid};
  assign rot       = NUM_REQ'(dbl >> rr_ptr);
  assign any_valid = |req_valid;

  // Scan from farthest to nearest so the nearest valid offset is the last one written.
  always_comb begin
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = PTR_W'(k);
    end
  end

  // Undo the rotation, wrapping past NUM_REQ-1 back to 0.
  always_comb begin
    sum  = {1'b0, rr_ptr} + {1'b0, offset};
    pick = (sum >= NUM_W) ? PTR_W'(sum - NUM_W) : sum[PTR_W-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                            wr_clk,
  input  logic                            wrst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  output logic [clog2(NUM_REQ)-1:0]       grant_id,
  output logic                            busy
);

  localparam int ID_W  = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  TOP_ID    = ID_W'(NUM_REQ - 1);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     owner, owner_nxt;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]    beat_cnt, beat_cnt_nxt;
  logic [ID_W-1:0]     pick;
  logic                any_valid;
  logic                owner_valid;
  logic                owner_last;
  logic                xfer;
  logic                burst_end;
  logic [DATA_WIDTH-1:0] slice [NUM_REQ];
  logic [DATA_WIDTH-1:0] owner_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign owner_valid = req_valid[owner];
  assign owner_last  = req_last[owner];
  assign owner_data  = slice[owner];
  assign busy        = (state == ST_BURST);
  assign grant_id    = owner;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .pick      (pick),
    .any_valid (any_valid)
  );

  // State, owner, round-robin pointer and beat counter registers.
  always_ff @(posedge wr_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= ST_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Next state plus write/ready decode; a full FIFO freezes everything in BURST.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    xfer         = 1'b0;
    burst_end    = 1'b0;
    fifo_wr_en   = 1'b0;
    req_ready    = '0;
    fifo_wr_data = '0;
    case (state)
      ST_IDLE: begin
        if (any_valid) begin
          owner_nxt    = pick;
          beat_cnt_nxt = '0;
          state_nxt    = ST_BURST;
        end
      end
      ST_BURST: begin
        fifo_wr_data = owner_data;
        xfer         = owner_valid & ~fifo_full;
        if (xfer) begin
          fifo_wr_en       = 1'b1;
          req_ready[owner] = 1'b1;
          beat_cnt_nxt     = beat_cnt + 1'b1;
        end
        // Abandonment only counts when the FIFO could have taken the beat.
        burst_end = (xfer & (owner_last | (beat_cnt == LAST_BEAT)))
                  | (~owner_valid & ~fifo_full);
        if (burst_end) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = (owner == TOP_ID) ? '0 : owner + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        wrst_n = 1'b0;
  logic        wrst1_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [3:0]  fifo_wr_data;
  logic [1:0]  grant_id;
  logic        busy;

  logic [3:0]  req_valid1 = 4'b0011;
  logic [15:0] req_data1 = 16'h00BA;
  logic [3:0]  req_last1 = 4'b0000;
  logic [3:0]  req_ready1;
  logic        fifo_full1 = 1'b0;
  logic        fifo_wr_en1;
  logic [3:0]  fifo_wr_data1;
  logic [1:0]  grant_id1;
  logic        busy1;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [4:0]  rq [4][$];
  logic [5:0]  exp_q [$];
  int          wr_cyc [$];
  logic [3:0]  hs_q = '0;
  int          log1_cyc [$];
  logic [1:0]  log1_id [$];

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .MAX_BURST(4)) dut (
    .wr_clk(clk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy)
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .MAX_BURST(1)) dut1 (
    .wr_clk(clk), .wrst_n(wrst1_n), .req_valid(req_valid1), .req_data(req_data1),
    .req_last(req_last1), .req_ready(req_ready1), .fifo_full(fifo_full1),
    .fifo_wr_en(fifo_wr_en1), .fifo_wr_data(fifo_wr_data1), .grant_id(grant_id1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Requester models: consume the beat handshaken last cycle, then present the next one.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs_q[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = rq[i][0][4];
        req_data[i*4 +: 4] = rq[i][0][3:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*4 +: 4] = 4'h0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [5:0] e;
    @(negedge clk);
    #1;
    hs_q = req_valid & req_ready;
    if (fifo_wr_en) begin
      chk("wr_while_full", {31'd0, fifo_full}, 32'd0);
      chk("ready_onehot", {28'd0, req_ready}, 32'd1 << grant_id);
      chk("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_beat", {26'd0, grant_id, fifo_wr_data}, {26'd0, e});
      end
      wr_cyc.push_back(cyc);
    end
    if (fifo_wr_en1 && log1_id.size() < 4) begin
      chk("t6_data", {28'd0, fifo_wr_data1}, (grant_id1 == 2'd1) ? 32'hB : 32'hA);
      log1_id.push_back(grant_id1);
      log1_cyc.push_back(cyc);
    end
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k;
    k = 0;
    while (wr_cyc.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("write_count_reached", {31'd0, wr_cyc.size() >= n}, 32'd1);
  endtask

  task automatic rst_pulse();
    wrst_n = 1'b0;
    tick();
    wrst_n = 1'b1;
  endtask

  initial begin
    int c;
    int w0;
    int k;

    // Reset state
    tick();
    tick();
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    chk("rst_data", {28'd0, fifo_wr_data}, 32'd0);
    wrst_n = 1'b1;
    tick();

    // Single requester, three beats with last on the third
    rq[0].push_back({1'b0, 4'hA});
    rq[0].push_back({1'b0, 4'hB});
    rq[0].push_back({1'b1, 4'hC});
    exp_q.push_back({2'd0, 4'hA});
    exp_q.push_back({2'd0, 4'hB});
    exp_q.push_back({2'd0, 4'hC});
    wr_cyc.delete();
    c = cyc;
    wait_writes(3, 20);
    chk("t1_first_latency", wr_cyc[0], c + 2);
    chk("t1_beat2", wr_cyc[1], c + 3);
    chk("t1_beat3", wr_cyc[2], c + 4);
    tick();
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_idle_data", {28'd0, fifo_wr_data}, 32'd0);
    chk("t1_rr_ptr", {30'd0, dut.rr_ptr}, 32'd1);
    chk("t1_total", wr_cyc.size(), 3);

    // All four continuously valid, no last: grants 0,1,2,3,0 of 4 beats each
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < ((i == 0) ? 8 : 4); b++) rq[i].push_back({1'b0, 2'(i), 2'(b)});
    end
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) exp_q.push_back({2'(g % 4), 2'(g % 4), 2'(b)});
    end
    wr_cyc.delete();
    c = cyc;
    wait_writes(20, 60);
    for (int j = 0; j < 20; j++) chk("t2_beat_cycle", wr_cyc[j], c + 2 + j + j / 4);
    tick();
    chk("t2_idle", {31'd0, busy}, 32'd0);
    chk("t2_total", wr_cyc.size(), 20);

    // FIFO full for two cycles after the first beat of a 4-beat burst
    for (int b = 0; b < 4; b++) begin
      rq[1].push_back({1'b0, 4'(5 + b)});
      exp_q.push_back({2'd1, 4'(5 + b)});
    end
    wr_cyc.delete();
    wait_writes(1, 20);
    w0 = wr_cyc[0];
    @(posedge clk);
    #1;
    fifo_full = 1'b1;
    for (int s = 0; s < 2; s++) begin
      tick();
      chk("t3_stall_wr_en", {31'd0, fifo_wr_en}, 32'd0);
      chk("t3_stall_ready", {28'd0, req_ready}, 32'd0);
      chk("t3_stall_cnt", {29'd0, dut.beat_cnt}, 32'd1);
      chk("t3_stall_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    wait_writes(4, 20);
    chk("t3_resume", wr_cyc[1], w0 + 3);
    chk("t3_last", wr_cyc[3], w0 + 5);
    tick();
    chk("t3_idle", {31'd0, busy}, 32'd0);
    chk("t3_total", wr_cyc.size(), 4);

    // Owner 1 abandons after two beats, requester 2 pending
    rst_pulse();
    rq[1].push_back({1'b0, 4'h1});
    rq[1].push_back({1'b0, 4'h2});
    rq[2].push_back({1'b0, 4'h3});
    rq[2].push_back({1'b1, 4'h4});
    exp_q.push_back({2'd1, 4'h1});
    exp_q.push_back({2'd1, 4'h2});
    exp_q.push_back({2'd2, 4'h3});
    exp_q.push_back({2'd2, 4'h4});
    wr_cyc.delete();
    wait_writes(2, 20);
    c = wr_cyc[1];
    tick();
    chk("t4_abandon_cycle_busy", {31'd0, busy}, 32'd1);
    chk("t4_abandon_cycle_wr", {31'd0, fifo_wr_en}, 32'd0);
    tick();
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_rr_ptr", {30'd0, dut.rr_ptr}, 32'd2);
    wait_writes(4, 20);
    chk("t4_next_grant_cycle", wr_cyc[2], c + 3);
    tick();

    // Reset mid-burst with owner 2
    rst_pulse();
    for (int b = 0; b < 3; b++) begin
      rq[2].push_back({1'b0, 4'(9 + b)});
      exp_q.push_back({2'd2, 4'(9 + b)});
    end
    wr_cyc.delete();
    wait_writes(1, 20);
    chk("t5_owner", {30'd0, grant_id}, 32'd2);
    wrst_n = 1'b0;
    #1;
    chk("t5_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("t5_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("t5_rst_data", {28'd0, fifo_wr_data}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_grant", {30'd0, grant_id}, 32'd0);
    @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) rq[i].delete();
    exp_q.delete();
    tick();
    tick();
    wrst_n = 1'b1;
    rq[0].push_back({1'b1, 4'h1});
    rq[2].push_back({1'b1, 4'h2});
    exp_q.push_back({2'd0, 4'h1});
    exp_q.push_back({2'd2, 4'h2});
    wr_cyc.delete();
    wait_writes(2, 20);
    tick();
    chk("t5_idle", {31'd0, busy}, 32'd0);

    // MAX_BURST=1 with requesters 0 and 1 valid
    wrst1_n = 1'b1;
    k = 0;
    while (log1_id.size() < 4 && k < 50) begin
      tick();
      k++;
    end
    chk("t6_count", log1_id.size(), 4);
    for (int j = 0; j < 4; j++) begin
      chk("t6_grant", {30'd0, log1_id[j]}, j % 2);
      chk("t6_spacing", log1_cyc[j], log1_cyc[0] + 2 * j);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
